multicycle_control: RTL

//  Multi-cycle main controller FSM. Sequences the shared-memory datapath (one ALU, one memory port, IR/MDR/A/B/ALUOut regs) through

---
 rtl/multicycle_control.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/writeback
// for base MIPS ops plus brv, jmxor, nandi, blezal, jalpc and baln.
// Optional feature macro: ILLEGAL_TRAP_EN (undecoded ops park in a sticky TRAP state).
// blezal/baln share one branch state and alu/nandi writeback share one state; a
// variant bit captured in DECODE picks the condition flag / destination there,
// and jmxor reuses the MEMRD wait state, so every state fits in STATE_W bits.
module multicycle_control #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               lez,
    input  logic               neg,
    input  logic               mem_ready,
    output logic               pcwrite,
    output logic               pcwritecond,
    output logic               iord,
    output logic               memread,
    output logic               memwrite,
    output logic               irwrite,
    output logic               memtoreg,
    output logic               regdst,
    output logic               regwrite,
    output logic               alusrca,
    output logic               linkwrite,
    output logic [1:0]         alusrcb,
    output logic [2:0]         aluop,
    output logic [1:0]         pcsrc,
    output logic               illegal,
    output logic [STATE_W-1:0] dbg_state
);

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_NANDI  = 6'b010000;
    localparam logic [5:0] OP_BLEZAL = 6'b100100;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JALPC  = 6'b011111;
    localparam logic [5:0] OP_BALN   = 6'b011011;
    localparam logic [5:0] FN_BRV    = 6'b010100;
    localparam logic [5:0] FN_JMXOR  = 6'b100011;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = STATE_W'(0),
        S_DECODE = STATE_W'(1),
        S_EXEC   = STATE_W'(2),
        S_REGWB  = STATE_W'(3),
        S_MEMADR = STATE_W'(4),
        S_MEMRD  = STATE_W'(5),
        S_MEMWB  = STATE_W'(6),
        S_MEMWR  = STATE_W'(7),
        S_BEQ    = STATE_W'(8),
        S_NANDI  = STATE_W'(9),
        S_BRCOND = STATE_W'(10),
        S_JUMP   = STATE_W'(11),
        S_JALPC  = STATE_W'(12),
        S_BRV    = STATE_W'(13),
        S_JMXWB  = STATE_W'(14)
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP = STATE_W'(15)
`endif
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_variant;
    logic   w_variant;
    logic   w_cond;
    logic   w_unused;

    // zero only qualifies pcwritecond inside the datapath
    assign w_unused  = zero;
    assign w_cond    = r_variant ? neg : lez;
    assign dbg_state = r_state;

    // State register and the variant bit latched while leaving DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_variant <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_variant <= w_variant;
        end
    end

    // Next-state: memory waits hold on mem_ready, DECODE dispatches on opcode/funct
    always_comb begin
        w_next    = r_state;
        w_variant = r_variant;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                w_variant = (opcode == OP_NANDI) || (opcode == OP_BALN);
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_BRV)        w_next = S_BRV;
                        else if (funct == FN_JMXOR) w_next = S_MEMRD;
                        else                        w_next = S_EXEC;
                    end
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_NANDI:     w_next = S_NANDI;
                    OP_BLEZAL,
                    OP_BALN:      w_next = S_BRCOND;
                    OP_J:         w_next = S_JUMP;
                    OP_JALPC:     w_next = S_JALPC;
`ifdef ILLEGAL_TRAP_EN
                    default:      w_next = S_TRAP;
`else
                    default:      w_next = S_FETCH;
`endif
                endcase
            end
            S_EXEC:   w_next = S_REGWB;
            S_NANDI:  w_next = S_REGWB;
            S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) w_next = (opcode == OP_RTYPE) ? S_JMXWB : S_MEMWB;
            S_MEMWR:  if (mem_ready) w_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:   w_next = S_TRAP;
`endif
            default:  w_next = S_FETCH;
        endcase
    end

    // Datapath controls decoded from the state register, all forced low in reset
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        linkwrite   = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 3'b000;
        pcsrc       = 2'b00;
        illegal     = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: alusrcb = 2'b11;
                S_EXEC: begin
                    alusrca = 1'b1;
                    aluop   = 3'b010;
                end
                S_REGWB: begin
                    regdst   = ~r_variant;
                    regwrite = 1'b1;
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    iord    = 1'b1;
                    memread = 1'b1;
                end
                S_MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                S_MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                S_BEQ: begin
                    alusrca     = 1'b1;
                    aluop       = 3'b001;
                    pcsrc       = 2'b01;
                    pcwritecond = 1'b1;
                end
                S_NANDI: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    aluop   = 3'b011;
                end
                S_BRCOND: begin
                    pcsrc       = 2'b01;
                    pcwritecond = w_cond;
                    linkwrite   = w_cond;
                    regwrite    = w_cond;
                end
                S_JUMP: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                end
                S_JALPC: begin
                    pcsrc     = 2'b01;
                    pcwrite   = 1'b1;
                    linkwrite = 1'b1;
                    regwrite  = 1'b1;
                end
                S_BRV: begin
                    pcsrc   = 2'b11;
                    pcwrite = 1'b1;
                end
                S_JMXWB: begin
                    aluop     = 3'b100;
                    pcsrc     = 2'b11;
                    pcwrite   = 1'b1;
                    linkwrite = 1'b1;
                    regwrite  = 1'b1;
                end
`ifdef ILLEGAL_TRAP_EN
                S_TRAP: illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule
